// File: rtl/startup_seq_pkg.sv
// rtl/startup_seq_pkg.sv - shared state and mode encodings for the startup edge sequencer
package startup_seq_pkg;

    typedef enum logic [1:0] {
        ST_ARMED = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic MODE_LEVEL = 1'b0;
    localparam logic MODE_PULSE = 1'b1;

endpackage

// File: rtl/startup_seq_chan.sv
// rtl/startup_seq_chan.sv - one sequenced output: set on its start count, optional clear after the pulse
module startup_seq_chan (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic rearm,
    input  logic hit_set,
    input  logic hit_clr,
    input  logic pulse_mode,
    output logic ch
);

    logic ch_q, ch_d;

    always_comb begin
        ch_d = ch_q;
        if (rearm) begin
            ch_d = 1'b0;
        end else if (en) begin
            if (hit_set) begin
                ch_d = 1'b1;
            end else if (hit_clr && pulse_mode) begin
                ch_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ch_q <= 1'b0;
        end else begin
            ch_q <= ch_d;
        end
    end

    assign ch = ch_q;

endmodule

// File: rtl/startup_edge_seq.sv
// rtl/startup_edge_seq.sv - counter-driven staggered release of CHANNELS outputs after reset
module startup_edge_seq
    import startup_seq_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_W     = 8,
    parameter int BASE      = 2,
    parameter int STEP      = 3,
    parameter int PULSE_LEN = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                rearm,
    input  logic                mode,
    output logic [CHANNELS-1:0] ch,
    output logic                done,
    output logic                busy,
    output logic [CNT_W-1:0]    count
);

    localparam int END_CNT = BASE + (CHANNELS - 1) * STEP + PULSE_LEN;
    localparam logic [CNT_W-1:0] END_C = CNT_W'(END_CNT);

    if (END_CNT >= (1 << CNT_W) || PULSE_LEN < 1 || STEP < 1 ||
        CHANNELS < 1 || CHANNELS > 16) begin : g_param_check
        $error("startup_edge_seq: illegal parameter combination");
    end

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             mode_q, mode_d;
    logic             run_edge;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        mode_d  = mode_q;
        if (rearm) begin
            state_d = ST_ARMED;
            count_d = '0;
        end else if (en) begin
            case (state_q)
                ST_ARMED: begin
                    mode_d  = mode;
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    // Final count is held, so the counter saturates at END.
                    if (count_q == END_C) begin
                        state_d = ST_DONE;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                ST_DONE: ;
                default: state_d = ST_ARMED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_ARMED;
            count_q <= '0;
            mode_q  <= MODE_LEVEL;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            mode_q  <= mode_d;
        end
    end

    assign run_edge = en && (state_q == ST_RUN);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        localparam logic [CNT_W-1:0] T_SET = CNT_W'(BASE + k * STEP);
        localparam logic [CNT_W-1:0] T_CLR = CNT_W'(BASE + k * STEP + PULSE_LEN);

        startup_seq_chan u_chan (
            .clk        (clk),
            .rst_n      (rst_n),
            .en         (run_edge),
            .rearm      (rearm),
            .hit_set    (count_q == T_SET),
            .hit_clr    (count_q == T_CLR),
            .pulse_mode (mode_q == MODE_PULSE),
            .ch         (ch[k])
        );
    end

    assign done  = (state_q == ST_DONE);
    assign busy  = (state_q == ST_RUN);
    assign count = count_q;

endmodule

// File: tb/tb_startup_edge_seq.sv
// tb/tb_startup_edge_seq.sv - self-checking bench for startup_edge_seq
module tb_startup_edge_seq;

    localparam int BASE = 2, STEP = 3, PL = 2, NCH = 4;
    localparam int END_CNT = BASE + (NCH - 1) * STEP + PL;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0, rearm = 1'b0, mode = 1'b0;
    logic [3:0] ch;
    logic       done, busy;
    logic [7:0] count;

    logic       en1 = 1'b0, rearm1 = 1'b0, mode1 = 1'b0;
    logic [0:0] ch1;
    logic       done1, busy1;
    logic [7:0] count1;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: number of enabled RUN edges since arming, capped at END+1.
    bit m_started;
    int m_n;
    bit m_mode;

    always #5 clk = ~clk;

    startup_edge_seq dut (
        .clk(clk), .rst_n(rst_n), .en(en), .rearm(rearm), .mode(mode),
        .ch(ch), .done(done), .busy(busy), .count(count)
    );

    startup_edge_seq #(.CHANNELS(1), .CNT_W(8), .BASE(0), .STEP(1), .PULSE_LEN(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .rearm(rearm1), .mode(mode1),
        .ch(ch1), .done(done1), .busy(busy1), .count(count1)
    );

    function automatic logic [3:0] exp_ch(int n, bit md);
        logic [3:0] r;
        r = '0;
        for (int k = 0; k < NCH; k++) begin
            int t;
            t = BASE + k * STEP;
            r[k] = (n > t) && (!md || n <= t + PL);
        end
        return r;
    endfunction

    function automatic logic [7:0] exp_count(int n);
        return (n > END_CNT) ? 8'(END_CNT) : 8'(n);
    endfunction

    task automatic step(input logic e, input logic ra, input logic md);
        en = e; rearm = ra; mode = md;
        @(posedge clk);
        if (ra) begin
            m_started = 0; m_n = 0;
        end else if (e) begin
            if (!m_started) begin
                m_started = 1; m_mode = md;
            end else if (m_n <= END_CNT) begin
                m_n++;
            end
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0; en = 1'b0; rearm = 1'b0; mode = 1'b0;
        en1 = 1'b0; rearm1 = 1'b0; mode1 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_started = 0; m_n = 0; m_mode = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (ch !== 4'b0 || done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_values: got ch=%b done=%b busy=%b count=%0d want 0/0/0/0", ch, done, busy, count);
        end
        step(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (busy !== 1'b0 || count !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_en0_idle: got busy=%b count=%0d want 0/0", busy, count);
        end
    endtask

    task automatic test_pulse();
        logic [3:0] want;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step(1'b1, 1'b0, 1'b1);
            want = '0;
            for (int k = 0; k < NCH; k++) if (e >= 4 + 3 * k && e <= 5 + 3 * k) want[k] = 1'b1;
            n_checks++;
            if (ch !== want) begin
                n_fail++;
                $display("FAIL pulse_ch edge %0d: got %b want %b", e, ch, want);
            end
            n_checks++;
            if (done !== (e >= 15) || busy !== (e >= 1 && e < 15)) begin
                n_fail++;
                $display("FAIL pulse_done_busy edge %0d: got done=%b busy=%b want %b/%b", e, done, busy, e >= 15, e < 15);
            end
        end
        n_checks++;
        if (count !== 8'd13) begin
            n_fail++;
            $display("FAIL pulse_count_hold: got %0d want 13", count);
        end
    endtask

    task automatic test_level();
        logic [3:0] want;
        do_reset();
        for (int e = 1; e <= 20; e++) begin
            step(1'b1, 1'b0, 1'b0);
            want = '0;
            for (int k = 0; k < NCH; k++) if (e >= 4 + 3 * k) want[k] = 1'b1;
            n_checks++;
            if (ch !== want || done !== (e >= 15)) begin
                n_fail++;
                $display("FAIL level edge %0d: got ch=%b done=%b want ch=%b done=%b", e, ch, done, want, e >= 15);
            end
        end
        n_checks++;
        if (ch !== 4'b1111 || count !== 8'd13) begin
            n_fail++;
            $display("FAIL level_final: got ch=%b count=%0d want 1111/13", ch, count);
        end
    endtask

    task automatic test_en_gating();
        do_reset();
        for (int e = 1; e <= 25; e++) begin
            step((e < 5 || e > 9), 1'b0, 1'b1);
            n_checks++;
            if (ch !== exp_ch(m_n, m_mode) || count !== exp_count(m_n)) begin
                n_fail++;
                $display("FAIL en_gate_model edge %0d: got ch=%b count=%0d want ch=%b count=%0d",
                         e, ch, count, exp_ch(m_n, m_mode), exp_count(m_n));
            end
            if (e >= 5 && e <= 9) begin
                n_checks++;
                if (count !== 8'd3 || ch[0] !== 1'b1) begin
                    n_fail++;
                    $display("FAIL en_gate_frozen edge %0d: got count=%0d ch0=%b want 3/1", e, count, ch[0]);
                end
            end
            if (e == 11 || e == 12) begin
                n_checks++;
                if (ch[0] !== 1'b0 || ch[1] !== (e == 12)) begin
                    n_fail++;
                    $display("FAIL en_gate_shift edge %0d: got ch=%b", e, ch);
                end
            end
        end
    endtask

    task automatic test_rearm();
        do_reset();
        for (int e = 1; e <= 7; e++) step(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (ch !== 4'b0010) begin
            n_fail++;
            $display("FAIL rearm_pre: got ch=%b want 0010", ch);
        end
        step(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (ch !== 4'b0 || count !== 8'd0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_clear: got ch=%b count=%0d busy=%b done=%b want 0/0/0/0", ch, count, busy, done);
        end
        for (int e = 9; e <= 24; e++) begin
            step(1'b1, 1'b0, 1'b0);
            n_checks++;
            if (ch[0] !== (e >= 12) || ch !== exp_ch(m_n, m_mode)) begin
                n_fail++;
                $display("FAIL rearm_replay edge %0d: got ch=%b want ch=%b", e, ch, exp_ch(m_n, m_mode));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int e = 1; e <= 8; e++) step(1'b1, 1'b0, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (ch !== 4'b0 || done !== 1'b0 || busy !== 1'b0 || count !== 8'd0) begin
            n_fail++;
            $display("FAIL async_reset: got ch=%b done=%b busy=%b count=%0d want 0/0/0/0", ch, done, busy, count);
        end
        m_started = 0; m_n = 0; m_mode = 0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int e = 1; e <= 16; e++) begin
            step(1'b1, 1'b0, 1'b1);
            n_checks++;
            if (ch !== exp_ch(m_n, m_mode) || ch[0] !== (e == 4 || e == 5) || done !== (e >= 15)) begin
                n_fail++;
                $display("FAIL async_replay edge %0d: got ch=%b done=%b want ch=%b done=%b",
                         e, ch, done, exp_ch(m_n, m_mode), e >= 15);
            end
        end
    endtask

    task automatic test_single_channel();
        do_reset();
        en1 = 1'b1; mode1 = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            step(1'b0, 1'b0, 1'b0);
            n_checks++;
            if (ch1[0] !== (e == 2) || done1 !== (e >= 3)) begin
                n_fail++;
                $display("FAIL single_chan edge %0d: got ch=%b done=%b want %b/%b", e, ch1[0], done1, e == 2, e >= 3);
            end
        end
        n_checks++;
        if (count1 !== 8'd1 || busy1 !== 1'b0) begin
            n_fail++;
            $display("FAIL single_chan_final: got count=%0d busy=%b want 1/0", count1, busy1);
        end
        en1 = 1'b0;
    endtask

    task automatic test_random();
        logic e, ra, md;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            e  = ($urandom_range(0, 9) != 0);
            ra = ($urandom_range(0, 39) == 0);
            md = 1'($urandom_range(0, 1));
            step(e, ra, md);
            n_checks++;
            if (ch !== exp_ch(m_n, m_mode) || count !== exp_count(m_n) ||
                done !== (m_n > END_CNT) || busy !== (m_started && m_n <= END_CNT)) begin
                n_fail++;
                $display("FAIL random cycle %0d: got ch=%b cnt=%0d done=%b busy=%b want ch=%b cnt=%0d done=%b busy=%b",
                         i, ch, count, done, busy, exp_ch(m_n, m_mode), exp_count(m_n),
                         m_n > END_CNT, m_started && m_n <= END_CNT);
            end
        end
    endtask

    initial begin
        test_reset();
        test_pulse();
        test_level();
        test_en_gating();
        test_rearm();
        test_async_reset();
        test_single_channel();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
